cam_line_wr: RTL and testbench
==============================

CAM_LINE_WR -- requirements
Module: cam_line_wr

Interface
REQ-001 The module SHALL provide parameter data_width, default 8, as the camera data and RAM write-data width.
REQ-002 The module SHALL provide parameter adr_width, default 9, as the RAM write-address width: MSB is the bank, low adr_width-1 bits are the column.
REQ-003 CLK  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 XRST  in  1  reset, synchronous and active-low.
REQ-005 CAM_PCLK  in  1  camera pixel clock, asynchronous, sampled as data.
REQ-006 CAM_VSYNC  in  1  camera frame sync, asynchronous, high = vertical blanking.
REQ-007 CAM_HREF  in  1  camera line valid, asynchronous, high = active pixels.
REQ-008 CAM_D  in  data_width  camera pixel byte, asynchronous.
REQ-009 WEN  out  1  RAM write enable, one-CLK pulse per stored byte.
REQ-010 WADR  out  adr_width  RAM write address {bank, column}.
REQ-011 WDAT  out  data_width  RAM write data.
REQ-012 LINE_RDY  out  1  a completed line is available to the consumer.
REQ-013 LINE_BANK  out  1  bank holding the ready line; valid while LINE_RDY=1.
REQ-014 LINE_LEN  out  adr_width  byte count of the ready line (1..2^(adr_width-1)).
REQ-015 LINE_ACK  in  1  consumer has finished reading the ready line.
REQ-016 OVF  out  1  sticky error: column overflow or line dropped.

Function
REQ-017 CAM_PCLK, CAM_VSYNC, CAM_HREF and CAM_D SHALL each pass through a two-flop synchroniser; a PCLK rise SHALL be detected when the second sync stage is 1 and a third delay stage is 0.
REQ-018 The FSM SHALL have states IDLE, FRAME and LINE; reset enters IDLE; IDLE->FRAME on a synchronised VSYNC falling edge; FRAME->LINE when HREF=1; LINE->FRAME when HREF=0; any state->IDLE when VSYNC=1.
REQ-019 In LINE, each detected PCLK rise SHALL produce WEN=1 exactly one CLK later, with WDAT equal to the synchronised CAM_D and WADR={bank, column}; the column SHALL then increment.
REQ-020 A write with column = 2^(adr_width-1)-1 SHALL be the last write of the line; further bytes SHALL be dropped and OVF set.
REQ-021 On LINE->FRAME with column>0 and LINE_RDY=0: LINE_RDY=1, LINE_BANK=bank, LINE_LEN=bytes written, bank toggles, column clears, all on the next CLK.
REQ-022 On LINE->FRAME with LINE_RDY=1 and no LINE_ACK in that cycle: the line SHALL be discarded, bank unchanged, column cleared, OVF set.
REQ-023 LINE_ACK=1 while LINE_RDY=1 SHALL clear LINE_RDY on the next CLK; LINE_ACK while LINE_RDY=0 SHALL be ignored.
REQ-024 LINE_ACK coincident with a line completion SHALL leave LINE_RDY=1 carrying the new LINE_BANK/LINE_LEN; no line SHALL be dropped.
REQ-025 A line with zero bytes SHALL not raise LINE_RDY.
REQ-026 VSYNC=1 during LINE SHALL abort the line: no LINE_RDY, column cleared, bank unchanged.
REQ-027 OVF SHALL clear on the IDLE->FRAME transition.

Reset
REQ-028 While XRST=0 on a CLK edge: state=IDLE, WEN=0, WADR=0, WDAT=0, LINE_RDY=0, LINE_BANK=0, LINE_LEN=0, OVF=0, bank=0, column=0, synchroniser stages=0.
REQ-029 Reset asserted mid-line SHALL discard the partial line with no further WEN.

Configuration
REQ-030 With CAM_DECIMATE_EN defined, only even-indexed bytes of each line (0, 2, 4, ...) SHALL be written, so LINE_LEN counts stored bytes; without it every byte SHALL be written.

Structure
REQ-031 FSM state encodings and the synchroniser depth SHALL live in the shared package cam_pkg.
REQ-032 The synchroniser plus edge detect SHALL be a sub-module cam_sync, instantiated once per input bit group.

Verification
REQ-033 Frame start, 4-byte line 0x11,0x22,0x33,0x44 -> WEN at WADR 0x000..0x003 with those data; LINE_RDY=1, LINE_BANK=0, LINE_LEN=4.
REQ-034 Second 3-byte line without LINE_ACK -> no WEN beyond bank 1 addresses 0x100..0x102; line dropped, OVF=1, LINE_BANK still 0.
REQ-035 LINE_ACK in the same cycle that a 2-byte bank-1 line completes -> LINE_RDY stays 1, LINE_BANK=1, LINE_LEN=2.
REQ-036 Line of 300 bytes, adr_width=9 -> 256 writes, last at column 255, LINE_LEN=256, OVF=1.
REQ-037 VSYNC rises after byte 2 of a line -> no LINE_RDY; XRST=0 mid-line -> all outputs 0 on the next CLK.
REQ-038 CAM_DECIMATE_EN defined, 6-byte line 0..5 -> writes 0, 2, 4 only; LINE_LEN=3.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the camera line writer: FSM encoding and synchroniser depth.
package cam_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_LINE  = 2'd2
  } cam_st_e;

  // Rising / falling edge of a synchronised level against its one-cycle-late copy.
  function automatic logic edge_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  function automatic logic edge_fall(input logic cur, input logic prev);
    return ~cur & prev;
  endfunction

endpackage

// File: rtl/cam_sync.sv
// Multi-flop synchroniser for one group of asynchronous camera inputs, plus a
// delay stage giving per-bit rise/fall pulses in the CLK domain.
module cam_sync
  import cam_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         XRST,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q,
  output logic [W-1:0] RISE,
  output logic [W-1:0] FALL
);

  logic [SYNC_STAGES-1:0][W-1:0] stg;
  logic [W-1:0]                  dly;

  always_ff @(posedge CLK) begin
    if (!XRST) begin
      stg <= '0;
      dly <= '0;
    end else begin
      stg[0] <= D;
      for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
      dly <= stg[SYNC_STAGES-1];
    end
  end

  assign Q = stg[SYNC_STAGES-1];

  for (genvar b = 0; b < W; b++) begin : g_edge
    assign RISE[b] = edge_rise(Q[b], dly[b]);
    assign FALL[b] = edge_fall(Q[b], dly[b]);
  end

endmodule

// File: rtl/cam_line_wr.sv
// Camera line capture into a double-banked line RAM with a ready/ack handshake.
// Define CAM_DECIMATE_EN to store only the even-indexed bytes of each line.
module cam_line_wr
  import cam_pkg::*;
#(
  parameter int data_width = 8,
  parameter int adr_width  = 9
) (
  input  logic                  CLK,
  input  logic                  XRST,
  input  logic                  CAM_PCLK,
  input  logic                  CAM_VSYNC,
  input  logic                  CAM_HREF,
  input  logic [data_width-1:0] CAM_D,
  output logic                  WEN,
  output logic [adr_width-1:0]  WADR,
  output logic [data_width-1:0] WDAT,
  output logic                  LINE_RDY,
  output logic                  LINE_BANK,
  output logic [adr_width-1:0]  LINE_LEN,
  input  logic                  LINE_ACK,
  output logic                  OVF
);

  localparam int                 CW  = adr_width - 1;
  localparam logic [adr_width-1:0] ONE = adr_width'(1);

  logic                  unused_pclk_q, pclk_rise, unused_pclk_fall;
  logic                  vs_s, unused_vs_rise, vs_fall;
  logic                  href_s, unused_href_rise, unused_href_fall;
  logic [data_width-1:0] d_s, unused_d_rise, unused_d_fall;

  cam_sync #(.W(1)) u_sync_pclk (
    .CLK(CLK), .XRST(XRST), .D(CAM_PCLK),
    .Q(unused_pclk_q), .RISE(pclk_rise), .FALL(unused_pclk_fall)
  );

  cam_sync #(.W(1)) u_sync_vsync (
    .CLK(CLK), .XRST(XRST), .D(CAM_VSYNC),
    .Q(vs_s), .RISE(unused_vs_rise), .FALL(vs_fall)
  );

  cam_sync #(.W(1)) u_sync_href (
    .CLK(CLK), .XRST(XRST), .D(CAM_HREF),
    .Q(href_s), .RISE(unused_href_rise), .FALL(unused_href_fall)
  );

  cam_sync #(.W(data_width)) u_sync_data (
    .CLK(CLK), .XRST(XRST), .D(CAM_D),
    .Q(d_s), .RISE(unused_d_rise), .FALL(unused_d_fall)
  );

  cam_st_e              state, nstate;
  logic [adr_width-1:0] cnt;   // bytes stored in the current line; MSB set = line full
  logic                 bank;

  logic byte_stb, keep, full, wr_fire, drop;
  logic line_end, has_data, publish, discard, frame_start;

  always_comb begin
    nstate = state;
    if (vs_s) nstate = ST_IDLE;
    else begin
      case (state)
        ST_IDLE:  if (vs_fall) nstate = ST_FRAME;
        ST_FRAME: if (href_s)  nstate = ST_LINE;
        ST_LINE:  if (!href_s) nstate = ST_FRAME;
        default:  nstate = ST_IDLE;
      endcase
    end
  end

  assign byte_stb = (state == ST_LINE) && !vs_s && href_s && pclk_rise;

`ifdef CAM_DECIMATE_EN
  logic phase;  // 0 = even byte index within the line
  assign keep = byte_stb && !phase;

  always_ff @(posedge CLK) begin
    if (!XRST)                 phase <= 1'b0;
    else if (state != ST_LINE) phase <= 1'b0;
    else if (byte_stb)         phase <= ~phase;
  end
`else
  assign keep = byte_stb;
`endif

  assign full        = cnt[adr_width-1];
  assign wr_fire     = keep && !full;
  assign drop        = keep && full;
  assign line_end    = (state == ST_LINE) && !vs_s && !href_s;
  assign has_data    = (cnt != '0);
  assign publish     = line_end && has_data && (!LINE_RDY || LINE_ACK);
  assign discard     = line_end && has_data && LINE_RDY && !LINE_ACK;
  assign frame_start = (state == ST_IDLE) && (nstate == ST_FRAME);

  always_ff @(posedge CLK) begin
    if (!XRST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bank      <= 1'b0;
      WEN       <= 1'b0;
      WADR      <= '0;
      WDAT      <= '0;
      LINE_RDY  <= 1'b0;
      LINE_BANK <= 1'b0;
      LINE_LEN  <= '0;
      OVF       <= 1'b0;
    end else begin
      state <= nstate;
      WEN   <= wr_fire;

      if (wr_fire) begin
        WADR <= {bank, cnt[CW-1:0]};
        WDAT <= d_s;
      end

      // Column only survives while staying in LINE; end, abort and idle all clear it.
      if (state != ST_LINE || nstate != ST_LINE) cnt <= '0;
      else if (wr_fire)                         cnt <= cnt + ONE;

      if (frame_start)          OVF <= 1'b0;
      else if (drop || discard) OVF <= 1'b1;

      // A completing line wins over a coincident ack, so nothing is lost.
      if (publish) begin
        LINE_RDY  <= 1'b1;
        LINE_BANK <= bank;
        LINE_LEN  <= cnt;
        bank      <= ~bank;
      end else if (LINE_RDY && LINE_ACK) begin
        LINE_RDY <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cam_line_wr.sv
// Directed bench for cam_line_wr; expectations follow CAM_DECIMATE_EN when defined.
module tb_cam_line_wr;

  localparam int DW = 8;
  localparam int AW = 9;
`ifdef CAM_DECIMATE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          XRST, CAM_PCLK, CAM_VSYNC, CAM_HREF, LINE_ACK;
  logic [DW-1:0] CAM_D;
  logic          WEN, LINE_RDY, LINE_BANK, OVF;
  logic [AW-1:0] WADR, LINE_LEN;
  logic [DW-1:0] WDAT;

  int n_run  = 0;
  int n_fail = 0;

  logic [AW-1:0] cap_adr[$];
  logic [DW-1:0] cap_dat[$];

  always #5 CLK = ~CLK;

  cam_line_wr #(.data_width(DW), .adr_width(AW)) dut (
    .CLK(CLK), .XRST(XRST), .CAM_PCLK(CAM_PCLK), .CAM_VSYNC(CAM_VSYNC),
    .CAM_HREF(CAM_HREF), .CAM_D(CAM_D), .WEN(WEN), .WADR(WADR), .WDAT(WDAT),
    .LINE_RDY(LINE_RDY), .LINE_BANK(LINE_BANK), .LINE_LEN(LINE_LEN),
    .LINE_ACK(LINE_ACK), .OVF(OVF)
  );

  always @(negedge CLK) begin
    if (WEN === 1'b1) begin
      cap_adr.push_back(WADR);
      cap_dat.push_back(WDAT);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_seq(input int n, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < n; i++) begin
      CAM_D = base + 8'(i) * step;
      cyc(4);
      CAM_PCLK = 1'b1;
      cyc(4);
      CAM_PCLK = 1'b0;
    end
  endtask

  task automatic new_frame();
    CAM_VSYNC = 1'b1;
    cyc(6);
    CAM_VSYNC = 1'b0;
    cyc(6);
  endtask

  task automatic line_start();
    CAM_HREF = 1'b1;
    cyc(6);
  endtask

  task automatic line_stop();
    cyc(4);
    CAM_HREF = 1'b0;
    cyc(8);
  endtask

  task automatic ack();
    LINE_ACK = 1'b1;
    cyc(1);
    LINE_ACK = 1'b0;
    cyc(2);
  endtask

  // Expected write stream of one line: stored bytes go to consecutive columns of bank b.
  task automatic chk_writes(input string tag, input int n, input logic [7:0] base,
                            input logic [7:0] step, input logic b);
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    int k = 0;
    for (int i = 0; i < n; i++) begin
      if (!DEC || (i % 2 == 0)) begin
        if (k < 256) begin
          ea.push_back((AW'(b) << 8) | AW'(k));
          ed.push_back(base + 8'(i) * step);
        end
        k++;
      end
    end
    chk({tag, "_nwr"}, cap_adr.size(), ea.size());
    for (int j = 0; j < ea.size() && j < cap_adr.size(); j++) begin
      chk($sformatf("%s_adr%0d", tag, j), cap_adr[j], ea[j]);
      chk($sformatf("%s_dat%0d", tag, j), cap_dat[j], ed[j]);
    end
    cap_adr.delete();
    cap_dat.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wen"},  WEN, 0);
    chk({tag, "_wadr"}, WADR, 0);
    chk({tag, "_wdat"}, WDAT, 0);
    chk({tag, "_rdy"},  LINE_RDY, 0);
    chk({tag, "_bank"}, LINE_BANK, 0);
    chk({tag, "_len"},  LINE_LEN, 0);
    chk({tag, "_ovf"},  OVF, 0);
  endtask

  initial begin
    XRST = 1'b0; CAM_PCLK = 1'b0; CAM_VSYNC = 1'b1; CAM_HREF = 1'b0;
    CAM_D = '0; LINE_ACK = 1'b0;
    cyc(3);
    chk_zero("reset");
    XRST = 1'b1;
    cyc(2);

    // 4-byte line into bank 0
    new_frame();
    line_start();
    send_seq(4, 8'h11, 8'h11);
    line_stop();
    chk_writes("l0", 4, 8'h11, 8'h11, 1'b0);
    chk("l0_rdy",  LINE_RDY, 1);
    chk("l0_bank", LINE_BANK, 0);
    chk("l0_len",  LINE_LEN, DEC ? 2 : 4);
    chk("l0_ovf",  OVF, 0);

    // second line while first still pending: written to bank 1, then dropped
    line_start();
    send_seq(3, 8'h55, 8'h11);
    line_stop();
    chk_writes("l1", 3, 8'h55, 8'h11, 1'b1);
    chk("l1_rdy",  LINE_RDY, 1);
    chk("l1_bank", LINE_BANK, 0);
    chk("l1_len",  LINE_LEN, DEC ? 2 : 4);
    chk("l1_ovf",  OVF, 1);

    // ack lands on the exact cycle the bank-1 line completes
    line_start();
    send_seq(2, 8'h88, 8'h11);
    cyc(4);
    CAM_HREF = 1'b0;
    cyc(2);
    LINE_ACK = 1'b1;
    cyc(1);
    LINE_ACK = 1'b0;
    cyc(6);
    chk_writes("l2", 2, 8'h88, 8'h11, 1'b1);
    chk("l2_rdy",  LINE_RDY, 1);
    chk("l2_bank", LINE_BANK, 1);
    chk("l2_len",  LINE_LEN, DEC ? 1 : 2);
    chk("l2_ovf",  OVF, 1);

    ack();
    chk("ack_rdy", LINE_RDY, 0);
    ack();
    chk("ack2_rdy",  LINE_RDY, 0);
    chk("ack2_bank", LINE_BANK, 1);

    // 300-byte line overflows the 256-column bank 0
    new_frame();
    chk("fr_ovf_clr", OVF, 0);
    line_start();
    send_seq(300, 8'h00, 8'h01);
    line_stop();
    chk_writes("l3", 300, 8'h00, 8'h01, 1'b0);
    chk("l3_rdy",  LINE_RDY, 1);
    chk("l3_bank", LINE_BANK, 0);
    chk("l3_len",  LINE_LEN, DEC ? 150 : 256);
    chk("l3_ovf",  OVF, DEC ? 0 : 1);
    ack();

    // VSYNC aborts a line after 2 bytes; bank 1 stays current
    new_frame();
    line_start();
    send_seq(2, 8'hA1, 8'h01);
    cyc(4);
    CAM_VSYNC = 1'b1;
    cyc(6);
    CAM_HREF = 1'b0;
    cyc(4);
    chk_writes("ab", 2, 8'hA1, 8'h01, 1'b1);
    chk("ab_rdy", LINE_RDY, 0);
    CAM_VSYNC = 1'b0;
    cyc(6);
    line_start();
    send_seq(1, 8'hC5, 8'h01);
    line_stop();
    chk_writes("l4", 1, 8'hC5, 8'h01, 1'b1);
    chk("l4_rdy",  LINE_RDY, 1);
    chk("l4_bank", LINE_BANK, 1);
    chk("l4_len",  LINE_LEN, 1);
    ack();

    // reset mid-line: outputs clear, partial line never completes
    new_frame();
    line_start();
    send_seq(2, 8'hD1, 8'h01);
    cyc(4);
    chk_writes("l5", 2, 8'hD1, 8'h01, 1'b0);
    XRST = 1'b0;
    cyc(1);
    chk_zero("mrst");
    send_seq(1, 8'hE1, 8'h01);
    XRST = 1'b1;
    send_seq(2, 8'hE2, 8'h01);
    line_stop();
    chk("mrst_nwr", cap_adr.size(), 0);
    chk("mrst_rdy", LINE_RDY, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
